delay_prog: RTL and testbench
=============================

DELAY_PROG -- requirements
Module: delay_prog

Interface
REQ-001 Parameter WIDTH, default 25, sample width in bits (signed two's complement).
REQ-002 Parameter DEPTH, default 16, buffer depth and maximum delay in valid beats.
REQ-003 Parameter DEFAULT_DELAY, default 7, delay in effect after reset.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high. Ports: clk and reset.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port data_in, input, WIDTH, signed input sample.
REQ-008 Port valid_in, input, 1, data_in is valid this cycle.
REQ-009 Port delay_sel, input, 5, requested delay in valid beats; sampled only when load=1.
REQ-010 Port load, input, 1, latch delay_sel and flush the pipeline.
REQ-011 Port data_out, output, WIDTH, signed delayed sample (registered).
REQ-012 Port valid_out, output, 1, data_out valid this cycle (registered).
REQ-013 Port primed, output, 1, high while in state RUN.

Function
REQ-014 Delay counts accepted valid beats, not clock cycles; idle cycles (valid_in=0) do not advance the pipeline.
REQ-015 Effective delay D = clamp(delay_sel, 1, DEPTH): 0 maps to 1; values above DEPTH map to DEPTH.
REQ-016 Each cycle with valid_in=1 SHALL write data_in to buffer[wr_ptr]; wr_ptr then increments modulo DEPTH.
REQ-017 States: FILL (fewer than D samples stored since last flush) and RUN (at least D stored).
REQ-018 In FILL, each accepted sample increments fill count; when count reaches D, the state becomes RUN and primed=1 on the following cycle.
REQ-019 The transition occurs on the D-th accepted sample; that sample does not produce an output.
REQ-020 In RUN, an accepted sample N SHALL produce valid_out=1 one cycle later, with data_out = sample N-D.
REQ-021 Buffer read SHALL return pre-write contents, so D=DEPTH is legal when read and write address the same slot.
REQ-022 Cycles with valid_in=0, or in FILL: valid_out=0 next cycle and data_out holds its last value.
REQ-023 load=1 in any state SHALL latch D from delay_sel, zero the fill count, and enter FILL; valid_out=0 next cycle.
REQ-024 load and valid_in together: the sample is accepted as the first sample of the new fill (count=1); with new D=1, the state goes to RUN immediately.
REQ-025 Data passes unmodified: no rounding, saturation or sign change; full WIDTH preserved.
REQ-026 wr_ptr and the read index (wr_ptr-D) SHALL wrap modulo DEPTH without gaps.

Reset
REQ-027 Asserting reset SHALL immediately clear data_out, valid_out, primed, wr_ptr and fill count to 0, set D=DEFAULT_DELAY, and set the state to FILL.
REQ-028 Buffer storage is not reset; no output may expose unwritten storage, as guaranteed by REQ-018.
REQ-029 Reset mid-stream discards all in-flight samples; the first output after reset is sample DEFAULT_DELAY's predecessor chain restarted from sample 0.

Structure
REQ-030 Shared package: state enumeration (FILL, RUN), DEFAULT_DELAY, and the clamp function for delay_sel.
REQ-031 One sub-module, delay_ram: DEPTH x WIDTH storage with one write port and one registered read-before-write port; no reset on the array.

Verification
REQ-032 Reset, then samples 1..20 (valid every cycle) -> primed rises after the 7th sample; outputs 1..13, each 1 cycle after samples 8..20.
REQ-033 load with delay_sel=3, then samples -5,-4,...,4 with valid_in toggling 1/0 -> outputs -5..1 only on the cycles after valid beats 4..10; valid_out=0 after idle cycles.
REQ-034 delay_sel=0 -> D=1, output equals the previous sample; delay_sel=31 -> D=16, first output follows the 17th sample, pointer wrap is verified over 40 samples.
REQ-035 Mid-RUN load with delay_sel=2, asserted with valid_in=1 and data 100, followed by 101 and 102 -> valid_out=0 until after 102; output is 100.
REQ-036 Reset asserted asynchronously between edges mid-RUN -> outputs cleared before the next edge; refill requires 7 new samples, and no pre-reset data appears.
REQ-037 Extremes -2^24 and 2^24-1 pass through with D=4 -> bit-exact signed values.

Source files
------------

// File: rtl/delay_prog_pkg.sv
// Shared definitions for the programmable beat-delay line.
//   state_t        : FILL (collecting D samples after a flush) / RUN (emitting)
//   DEFAULT_DELAY  : delay in effect after reset
//   clamp_delay()  : maps a raw 5-bit delay request onto the legal range 1..depth
package delay_prog_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DELAY = 7;

    function automatic int clamp_delay(input logic [4:0] sel, input int depth);
        if (sel == 5'd0) begin
            return 1;
        end
        if (int'(sel) > depth) begin
            return depth;
        end
        return int'(sel);
    endfunction

endpackage

// File: rtl/delay_ram.sv
// DEPTH x WIDTH sample store for delay_prog.
//   clk, reset        : clock; reset clears only the read register
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request, result registered into rd_data
//   rd_data           : read result; holds its value when rd_en is low
// The array itself has no reset. A read of the slot being written in the
// same cycle returns the old contents, which is what makes D = DEPTH work.
module delay_ram #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_prog.sv
// Programmable delay line counting valid beats rather than clock cycles.
//   clk, reset          : clock, asynchronous active-high reset
//   data_in, valid_in   : input sample stream
//   delay_sel, load     : load latches a new delay (clamped to 1..DEPTH) and flushes
//   data_out, valid_out : registered delayed stream; data_out holds when not valid
//   primed              : high while the line holds at least D samples (state RUN)
//
// state | meaning
// FILL  | fewer than D samples accepted since the last flush; no outputs
// RUN   | at least D samples stored; every accepted sample emits sample N-D
module delay_prog
    import delay_prog_pkg::*;
#(
    parameter int WIDTH         = 25,
    parameter int DEPTH         = 16,
    parameter int DEFAULT_DELAY = delay_prog_pkg::DEFAULT_DELAY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic                    valid_in,
    input  logic [4:0]              delay_sel,
    input  logic                    load,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    valid_out,
    output logic                    primed
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH + 1);

    state_t        state, state_next;
    logic [DW-1:0] d_reg;
    logic [DW-1:0] d_new;
    logic [DW-1:0] cnt, cnt_next, cnt_inc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [WIDTH-1:0] rd_data;
    int            rd_i;

    assign d_new   = DW'(clamp_delay(delay_sel, DEPTH));
    assign cnt_inc = cnt + DW'(1);

    // State register, together with the delay and fill counter it governs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
            cnt   <= '0;
            d_reg <= DW'(DEFAULT_DELAY);
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                d_reg <= d_new;
            end
        end
    end

    // A sample accepted with load counts as the first sample of the new fill.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (load) begin
            cnt_next   = valid_in ? DW'(1) : '0;
            state_next = (valid_in && d_new == DW'(1)) ? RUN : FILL;
        end else if (valid_in && state == FILL) begin
            cnt_next = cnt_inc;
            if (cnt_inc == d_reg) begin
                state_next = RUN;
            end
        end
    end

    always_comb begin
        primed = (state == RUN);
        rd_en  = valid_in && (state == RUN) && !load;
    end

    // Read index trails the write pointer by D, wrapping modulo DEPTH.
    always_comb begin
        rd_i = int'(wr_ptr) - int'(d_reg);
        if (rd_i < 0) begin
            rd_i = rd_i + DEPTH;
        end
        rd_addr = AW'(rd_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_en;
            if (valid_in) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
        end
    end

    delay_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (valid_in),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign data_out = rd_data;

endmodule

// File: tb/tb_delay_prog.sv
// Scoreboard bench for delay_prog: a history-based reference model pushes the
// expected output when a sample is driven; the entry is popped and compared
// when the DUT reports valid_out.
module tb_delay_prog;

    logic               clk;
    logic               reset;
    logic signed [24:0] data_in;
    logic               valid_in;
    logic [4:0]         delay_sel;
    logic               load;
    logic signed [24:0] data_out;
    logic               valid_out;
    logic               primed;

    int checks;
    int errors;

    logic signed [24:0] hist[$];
    logic signed [24:0] exp_q[$];
    logic signed [24:0] last_out;
    int                 dm;

    delay_prog dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .delay_sel (delay_sel),
        .load      (load),
        .data_out  (data_out),
        .valid_out (valid_out),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    function automatic int clamp_m(input int sel);
        if (sel < 1) return 1;
        if (sel > 16) return 16;
        return sel;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        dm       = 7;
        last_out = '0;
    endtask

    // One clock cycle of stimulus; outputs checked 1 time unit after the edge.
    task automatic drive(input logic v, input logic signed [24:0] d,
                         input logic ld, input logic [4:0] sel);
        logic exp_v;
        logic signed [24:0] e;
        exp_v     = 1'b0;
        valid_in  = v;
        data_in   = d;
        load      = ld;
        delay_sel = sel;
        if (ld) begin
            hist.delete();
            dm = clamp_m(int'(sel));
            if (v) hist.push_back(d);
        end else if (v) begin
            if (hist.size() >= dm) begin
                exp_q.push_back(hist[hist.size() - dm]);
                exp_v = 1'b1;
            end
            hist.push_back(d);
        end
        @(posedge clk);
        #1;
        check("valid_out", 64'(valid_out), 64'(exp_v));
        check("primed", 64'(primed), 64'(hist.size() >= dm));
        if (valid_out && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_out", 64'(data_out), 64'(e));
            last_out = e;
        end else if (!exp_v) begin
            check("data_hold", 64'(data_out), 64'(last_out));
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 5'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        data_in   = '0;
        valid_in  = 1'b0;
        delay_sel = '0;
        load      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_primed", 64'(primed), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Default delay 7, samples 1..20 back to back.
        for (int i = 1; i <= 20; i++) drive(1'b1, 25'(i), 1'b0, 5'd0);
        idle();

        // D=3 with valid toggling.
        drive(1'b0, '0, 1'b1, 5'd3);
        for (int i = -5; i <= 4; i++) begin
            drive(1'b1, 25'(i), 1'b0, 5'd0);
            idle();
        end

        // delay_sel=0 clamps to 1.
        drive(1'b0, '0, 1'b1, 5'd0);
        for (int i = 0; i < 10; i++) drive(1'b1, 25'($urandom), 1'b0, 5'd0);

        // delay_sel=31 clamps to 16; 40 samples cover several pointer wraps.
        drive(1'b0, '0, 1'b1, 5'd31);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 25'($urandom), 1'b0, 5'd0);
            if (i % 7 == 3) idle();
        end

        // Mid-RUN load together with a valid sample.
        drive(1'b1, 25'sd100, 1'b1, 5'd2);
        drive(1'b1, 25'sd101, 1'b0, 5'd0);
        drive(1'b1, 25'sd102, 1'b0, 5'd0);
        drive(1'b1, 25'sd103, 1'b0, 5'd0);
        drive(1'b1, 25'sd104, 1'b0, 5'd0);

        // Asynchronous reset between edges while in RUN.
        valid_in = 1'b0;
        load     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_data_out", 64'(data_out), 64'd0);
        check("async_valid_out", 64'(valid_out), 64'd0);
        check("async_primed", 64'(primed), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 25'(500 + i), 1'b0, 5'd0);

        // Full-scale extremes with D=4.
        drive(1'b0, '0, 1'b1, 5'd4);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i % 2 == 0) ? -25'sd16777216 : 25'sd16777215, 1'b0, 5'd0);
        end
        idle();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
